// File: rtl/lsb_pkg.sv
// Shared definitions for the lsb_gen board I/O peripheral: register map,
// red-LED write opcodes and the hex-digit segment table.
package lsb_pkg;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_EVT    = 2'd1;
   localparam logic [1:0] ADDR_LED    = 2'd2;
   localparam logic [1:0] ADDR_HEX    = 2'd3;

   // Opcode in data_in[31:30] of an LED register write.
   typedef enum logic [1:0] {
      LED_SET   = 2'b00,
      LED_CLR   = 2'b01,
      LED_TOG   = 2'b10,
      LED_GREEN = 2'b11
   } led_op_e;

   localparam logic [6:0] HEX_BLANK_N = 7'h7F;

   // Active-high segments {g,f,e,d,c,b,a}; the top inverts for the pins.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/lsb_debounce.sv
// One button: 2-FF synchroniser on the active-low pin, counter debounce,
// debounced active-high state and a one-cycle press (0->1) pulse.
module lsb_debounce #(
   parameter int DEB_BITS = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic state,
   output logic rise
);
   import lsb_pkg::*;

   logic                sync1;
   logic                sync2;
   logic                s;
   logic [DEB_BITS-1:0] cnt;

   // Synchroniser idles at the released (high) level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
      end
   end

   assign s = ~sync2;

   // Any sample agreeing with the current state restarts the stable period.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= 1'b0;
         cnt   <= '0;
      end else if (s == state) begin
         cnt <= '0;
      end else if (&cnt) begin
         state <= s;
         cnt   <= '0;
      end else begin
         cnt <= cnt + DEB_BITS'(1);
      end
   end

   assign rise = s & ~state & (&cnt);

endmodule

// File: rtl/lsb_gen.sv
// Board I/O peripheral: debounced buttons with sticky press events, synchronised
// switches, red/green LEDs and NUM_HEX 7-segment digits on a 2-bit register bus.
module lsb_gen #(
   parameter logic [3:0] BOARD     = 4'd3,
   parameter int         NUM_BTN   = 4,
   parameter int         NUM_SWI   = 10,
   parameter int         NUM_LED_R = 10,
   parameter int         NUM_LED_G = 8,
   parameter int         NUM_HEX   = 4,
   parameter int         DEB_BITS  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stb,
   input  logic                   we,
   input  logic [1:0]             addr,
   input  logic [31:0]            data_in,
   input  logic [NUM_LED_R-1:0]   leds_r_in,
   output logic [31:0]            data_out,
   output logic                   ack,
   input  logic [NUM_BTN-1:0]     btn_in_n,
   input  logic [NUM_SWI-1:0]     swi_in,
   output logic [NUM_LED_R-1:0]   leds_r,
   output logic [NUM_LED_G-1:0]   leds_g,
   output logic [7*NUM_HEX-1:0]   hex_n,
   output logic [NUM_BTN-1:0]     btn_out,
   output logic [NUM_SWI-1:0]     swi_out
);
   import lsb_pkg::*;

   // Bus handshake: a transfer completes in the cycle stb is high; ack mirrors
   // stb with no wait states, writes commit on the following clock edge.
   logic                 wr;
   logic                 rd;
   logic [NUM_BTN-1:0]   btn_state;
   logic [NUM_BTN-1:0]   btn_rise;
   logic [NUM_BTN-1:0]   evt;
   logic [NUM_BTN-1:0]   evt_clr;
   logic [NUM_SWI-1:0]   swi_s1;
   logic [NUM_SWI-1:0]   swi_s2;
   logic [NUM_LED_R-1:0] led_r_q;
   logic [NUM_LED_R-1:0] led_r_in_q;
   logic [NUM_LED_G-1:0] led_g_q;
   logic [7*NUM_HEX-1:0] hex_q;
   logic [3:0]           hex_sel;
   logic [6:0]           hex_val_n;
   logic                 unused_data;

   assign wr  = stb & we;
   assign rd  = stb & ~we;
   assign ack = stb;
   assign unused_data = ^data_in;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      lsb_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .btn_n (btn_in_n[i]),
         .state (btn_state[i]),
         .rise  (btn_rise[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         swi_s1 <= '0;
         swi_s2 <= '0;
      end else begin
         swi_s1 <= swi_in;
         swi_s2 <= swi_s1;
      end
   end

   // A press arriving with a clear of the same bit must not be lost.
   assign evt_clr = (wr && addr == ADDR_EVT) ? data_in[NUM_BTN-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         evt <= '0;
      end else begin
         evt <= (evt & ~evt_clr) | btn_rise;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_r_q    <= '0;
         led_g_q    <= '0;
         led_r_in_q <= '0;
      end else begin
         led_r_in_q <= leds_r_in;
         if (wr && addr == ADDR_LED) begin
            case (led_op_e'(data_in[31:30]))
               LED_SET:   led_r_q <= led_r_q | data_in[NUM_LED_R-1:0];
               LED_CLR:   led_r_q <= led_r_q & ~data_in[NUM_LED_R-1:0];
               LED_TOG:   led_r_q <= led_r_q ^ data_in[NUM_LED_R-1:0];
               LED_GREEN: led_g_q <= data_in[NUM_LED_G-1:0];
               default:   led_r_q <= led_r_q;
            endcase
         end
      end
   end

   assign hex_sel   = data_in[11:8];
   assign hex_val_n = data_in[4] ? HEX_BLANK_N : ~seg_decode(data_in[3:0]);

   // Selects beyond the last digit match no k and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         hex_q <= '1;
      end else if (wr && addr == ADDR_HEX) begin
         for (int k = 0; k < NUM_HEX; k++) begin
            if (hex_sel == 4'(k)) hex_q[7*k +: 7] <= hex_val_n;
         end
      end
   end

   always_comb begin
      data_out = '0;
      if (rd) begin
         case (addr)
            ADDR_STATUS: begin
               data_out[31:28]          = BOARD;
               data_out[16 +: NUM_BTN]  = btn_state;
               data_out[0 +: NUM_SWI]   = swi_s2;
            end
            ADDR_EVT: data_out[0 +: NUM_BTN] = evt;
            ADDR_LED: begin
               data_out[16 +: NUM_LED_G] = led_g_q;
               data_out[0 +: NUM_LED_R]  = led_r_q;
            end
            default: data_out = '0;
         endcase
      end
   end

   assign leds_r  = led_r_q | led_r_in_q;
   assign leds_g  = led_g_q;
   assign hex_n   = hex_q;
   assign btn_out = btn_state;
   assign swi_out = swi_s2;

endmodule
